elastic_flush_pipeline: RTL and testbench

ELASTIC_FLUSH_PIPELINE -- requirements
Module: elastic_flush_pipeline

---
 rtl/elastic_flush_pipeline_pkg.sv | 15 +
 rtl/elastic_flush_pipeline_if.sv | 38 +++
 rtl/elastic_flush_pipeline_stage.sv | 68 ++++++
 rtl/elastic_flush_pipeline.sv | 112 +++++++++++
 tb/tb_elastic_flush_pipeline.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elastic_flush_pipeline_pkg.sv
// Shared constants and helpers for the elastic flush pipeline.
package pipeline_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_ID_WIDTH      = 4;
  localparam int DEFAULT_DEPTH         = 4;
  localparam int DEFAULT_OFFSET_STEP   = 3;

  // Address offset added when an entry is loaded into stage k.
  function automatic int unsigned stage_offset(input int unsigned k,
                                               input int unsigned step = DEFAULT_OFFSET_STEP);
    return (k + 1) * step;
  endfunction

endpackage

// File: rtl/elastic_flush_pipeline_if.sv
// Request, response and flush signals of the elastic flush pipeline.
// master = the side that issues requests and consumes outputs, slave = the pipeline.
interface elastic_flush_pipeline_if
  import pipeline_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH
);

  localparam int KILL_WIDTH = $clog2(DEPTH + 2);
  localparam int OCC_WIDTH  = $clog2(DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] in_address;
  logic [ID_WIDTH-1:0]      in_id;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_flush;
  logic [ID_WIDTH-1:0]      in_flush_id;
  logic [ADDRESS_WIDTH-1:0] out_address;
  logic [ID_WIDTH-1:0]      out_id;
  logic                     out_valid;
  logic                     out_ready;
  logic                     flush_done;
  logic [KILL_WIDTH-1:0]    kill_count;
  logic [OCC_WIDTH-1:0]     occupancy;

  modport master (
    output in_address, in_id, in_valid, in_flush, in_flush_id, out_ready,
    input  in_ready, out_address, out_id, out_valid, flush_done, kill_count, occupancy
  );

  modport slave (
    input  in_address, in_id, in_valid, in_flush, in_flush_id, out_ready,
    output in_ready, out_address, out_id, out_valid, flush_done, kill_count, occupancy
  );

endinterface

// File: rtl/elastic_flush_pipeline_stage.sv
// One register stage: loads from upstream whenever it is empty or its own
// entry is leaving, adds its fixed address offset on load, and drops any
// entry (held or arriving) whose ID matches an active flush.
module elastic_stage
  import pipeline_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
  parameter int OFFSET_STEP   = DEFAULT_OFFSET_STEP,
  parameter int STAGE_INDEX   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_up_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_up_address,
  input  logic [ID_WIDTH-1:0]      i_up_id,
  input  logic                     i_down_ready,
  input  logic                     i_flush,
  input  logic [ID_WIDTH-1:0]      i_flush_id,
  output logic                     o_valid,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [ID_WIDTH-1:0]      o_id,
  output logic                     o_ready,
  output logic                     o_kill
);

  localparam logic [ADDRESS_WIDTH-1:0] LP_OFFSET =
    ADDRESS_WIDTH'(stage_offset(STAGE_INDEX, OFFSET_STEP));

  logic                     r_valid;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [ID_WIDTH-1:0]      r_id;

  logic                w_ready;
  logic                w_next_valid_raw;
  logic [ID_WIDTH-1:0] w_next_id;
  logic                w_kill;

  // Ready depends only on our own valid and the downstream ready, never on upstream valid.
  assign w_ready          = !r_valid || i_down_ready;
  // Entry that would occupy this stage after the edge if no flush were active.
  assign w_next_valid_raw = w_ready ? i_up_valid : r_valid;
  assign w_next_id        = w_ready ? i_up_id    : r_id;
  // A matching entry is killed where it lands, whether it stays or arrives.
  assign w_kill           = w_next_valid_raw && i_flush && (w_next_id == i_flush_id);

  // Stage register: hold when stalled, load (with offset) when the slot frees up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_address <= '0;
      r_id      <= '0;
    end else begin
      r_valid <= w_next_valid_raw && !w_kill;
      if (w_ready && i_up_valid) begin
        r_address <= i_up_address + LP_OFFSET;
        r_id      <= i_up_id;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_address = r_address;
  assign o_id      = r_id;
  assign o_ready   = w_ready;
  assign o_kill    = w_kill;

endmodule

// File: rtl/elastic_flush_pipeline.sv
// Elastic pipeline of DEPTH register stages with per-stage address jumbling
// and ID-selective flush. The last stage drives the output directly.
module elastic_flush_pipeline
  import pipeline_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int OFFSET_STEP   = DEFAULT_OFFSET_STEP
) (
  input logic                     clk,
  input logic                     reset,
  elastic_flush_pipeline_if.slave bus
);

  localparam int KW = $clog2(DEPTH + 2);
  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] w_valid_vec;
  logic [DEPTH-1:0] w_kill_vec;
  logic [KW-1:0]    w_kill_sum;
  logic [OW-1:0]    w_occupancy;
  logic [KW-1:0]    r_kill_count;
  logic             r_flush_done;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic                     w_up_valid;
      logic [ADDRESS_WIDTH-1:0] w_up_address;
      logic [ID_WIDTH-1:0]      w_up_id;
      logic                     w_down_ready;
      logic                     w_valid;
      logic [ADDRESS_WIDTH-1:0] w_address;
      logic [ID_WIDTH-1:0]      w_id;
      logic                     w_ready;
      logic                     w_kill;

      if (gi == 0) begin : g_head
        assign w_up_valid   = bus.in_valid;
        assign w_up_address = bus.in_address;
        assign w_up_id      = bus.in_id;
      end else begin : g_body
        assign w_up_valid   = g_stage[gi-1].w_valid;
        assign w_up_address = g_stage[gi-1].w_address;
        assign w_up_id      = g_stage[gi-1].w_id;
      end

      if (gi == DEPTH - 1) begin : g_tail
        assign w_down_ready = bus.out_ready;
      end else begin : g_link
        assign w_down_ready = g_stage[gi+1].w_ready;
      end

      elastic_stage #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .ID_WIDTH     (ID_WIDTH),
        .OFFSET_STEP  (OFFSET_STEP),
        .STAGE_INDEX  (gi)
      ) u_stage (
        .clk         (clk),
        .reset       (reset),
        .i_up_valid  (w_up_valid),
        .i_up_address(w_up_address),
        .i_up_id     (w_up_id),
        .i_down_ready(w_down_ready),
        .i_flush     (bus.in_flush),
        .i_flush_id  (bus.in_flush_id),
        .o_valid     (w_valid),
        .o_address   (w_address),
        .o_id        (w_id),
        .o_ready     (w_ready),
        .o_kill      (w_kill)
      );

      assign w_valid_vec[gi] = w_valid;
      assign w_kill_vec[gi]  = w_kill;
    end
  endgenerate

  // Count kills this cycle and valid stages; a dropped input shows up as a stage-0 kill.
  always_comb begin
    w_kill_sum  = '0;
    w_occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_sum  = w_kill_sum + KW'(w_kill_vec[i]);
      w_occupancy = w_occupancy + OW'(w_valid_vec[i]);
    end
  end

  // Flush status: done pulse follows every flush strobe, count held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_done <= 1'b0;
      r_kill_count <= '0;
    end else begin
      r_flush_done <= bus.in_flush;
      if (bus.in_flush) begin
        r_kill_count <= w_kill_sum;
      end
    end
  end

  assign bus.in_ready    = g_stage[0].w_ready;
  assign bus.out_valid   = g_stage[DEPTH-1].w_valid;
  assign bus.out_address = g_stage[DEPTH-1].w_address;
  assign bus.out_id      = g_stage[DEPTH-1].w_id;
  assign bus.flush_done  = r_flush_done;
  assign bus.kill_count  = r_kill_count;
  assign bus.occupancy   = w_occupancy;

endmodule

// File: tb/tb_elastic_flush_pipeline.sv
// Scoreboard bench for elastic_flush_pipeline (DEPTH=4, OFFSET_STEP=3, offset sum 30).
module tb_elastic_flush_pipeline;

  localparam logic [31:0] SUM = 32'd30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elastic_flush_pipeline_if #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .DEPTH(4)) bus ();
  elastic_flush_pipeline_if #(.ADDRESS_WIDTH(8),  .ID_WIDTH(4), .DEPTH(4)) bus8 ();

  elastic_flush_pipeline #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .DEPTH(4), .OFFSET_STEP(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  elastic_flush_pipeline #(.ADDRESS_WIDTH(8), .ID_WIDTH(4), .DEPTH(4), .OFFSET_STEP(3)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   out_cyc[$];
  exp_t mon_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Output monitor: every transfer is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got addr=%h id=%0d, required no output", bus.out_address, bus.out_id);
      end else begin
        mon_exp = exp_q.pop_front();
        out_cyc.push_back(cycle);
        if (bus.out_address !== mon_exp.addr || bus.out_id !== mon_exp.id) begin
          n_fail++;
          $display("FAIL out_data: got addr=%h id=%0d, required addr=%h id=%0d",
                   bus.out_address, bus.out_id, mon_exp.addr, mon_exp.id);
        end else begin
          $display("out  cycle %0d addr=%h id=%0d", cycle, bus.out_address, bus.out_id);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_address  = '0;
    bus.in_id       = '0;
    bus.in_flush    = 1'b0;
    bus.in_flush_id = '0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [3:0] id);
    exp_t e;
    e.addr = a;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] id);
    bus.in_valid   = 1'b1;
    bus.in_address = a;
    bus.in_id      = id;
    $display("in   cycle %0d addr=%h id=%0d", cycle, a, id);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    step();
  endtask

  task automatic test_reset();
    idle();
    bus.out_ready    = 1'b1;
    bus8.in_valid    = 1'b0;
    bus8.in_address  = '0;
    bus8.in_id       = '0;
    bus8.in_flush    = 1'b0;
    bus8.in_flush_id = '0;
    bus8.out_ready   = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        @(posedge clk);
        #1 reset = 1'b0;
      end else begin
        repeat (2) @(posedge clk);
      end
      @(negedge clk);
      n_checks += 5;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready ph%0d: got %b, required 1", ph, bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid ph%0d: got %b, required 0", ph, bus.out_valid); end
      if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy ph%0d: got %0d, required 0", ph, bus.occupancy); end
      if (bus.kill_count !== 3'd0) begin n_fail++; $display("FAIL reset_kill_count ph%0d: got %0d, required 0", ph, bus.kill_count); end
      if (bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done ph%0d: got %b, required 0", ph, bus.flush_done); end
    end
  endtask

  task automatic test_streaming();
    int start;
    idle();
    bus.out_ready = 1'b1;
    out_cyc.delete();
    step();
    start = cycle;
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + i, 4'(i));
      push_exp(32'h11E + i, 4'(i));
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready %0d: got %b, required 1", i, bus.in_ready); end
      step();
    end
    idle();
    drain(20);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_cyc.size() <= i) begin
        n_fail++; $display("FAIL stream_latency %0d: got no output, required cycle %0d", i, start + 4 + i);
      end else if (out_cyc[i] != start + 4 + i) begin
        n_fail++; $display("FAIL stream_latency %0d: got cycle %0d, required %0d", i, out_cyc[i], start + 4 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    idle();
    bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 6; i++) push_exp(32'h400 + i + SUM, 4'(i + 1));
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) drive(32'h400 + idx, 4'(idx + 1)); else idle();
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== (c < 4)) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b, required %b", c, bus.in_ready, (c < 4)); end
      if (bus.in_valid && bus.in_ready) idx++;
      step();
    end
    @(negedge clk);
    n_checks += 3;
    if (idx != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d, required 4", idx); end
    if (bus.occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occupancy: got %0d, required 4", bus.occupancy); end
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b, required 1", bus.out_valid); end
    step();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      drive(32'h400 + idx, 4'(idx + 1));
      @(negedge clk);
      if (bus.in_ready) idx++;
      step();
    end
    idle();
    drain(20);
    n_checks++;
    if (exp_q.size() != 0 || idx != 6) begin n_fail++; $display("FAIL bp_drain: got %0d pending %0d sent, required 0 pending 6 sent", exp_q.size(), idx); exp_q.delete(); end
  endtask

  task automatic test_flush();
    logic [3:0] ids [4] = '{4'd1, 4'd2, 4'd1, 4'd3};
    idle();
    bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      drive(32'h200 + i, ids[i]);
      if (ids[i] != 4'd1) push_exp(32'h200 + i + SUM, ids[i]);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_fill_ready %0d: got %b, required 1", i, bus.in_ready); end
      step();
    end
    idle();
    step();
    // Non-matching flush first: nothing changes, count 0.
    bus.in_flush = 1'b1; bus.in_flush_id = 4'd7;
    @(negedge clk);
    n_checks++;
    if (bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_done_early: got %b, required 0", bus.flush_done); end
    step();
    bus.in_flush = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (bus.flush_done !== 1'b1) begin n_fail++; $display("FAIL nomatch_done: got %b, required 1", bus.flush_done); end
    if (bus.kill_count !== 3'd0) begin n_fail++; $display("FAIL nomatch_kill: got %0d, required 0", bus.kill_count); end
    if (bus.occupancy !== 3'd4) begin n_fail++; $display("FAIL nomatch_occupancy: got %0d, required 4", bus.occupancy); end
    step();
    bus.in_flush = 1'b1; bus.in_flush_id = 4'd1;
    $display("flush cycle %0d id=1", cycle);
    @(negedge clk);
    step();
    bus.in_flush = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (bus.flush_done !== 1'b1) begin n_fail++; $display("FAIL flush_done: got %b, required 1", bus.flush_done); end
    if (bus.kill_count !== 3'd2) begin n_fail++; $display("FAIL flush_kill: got %0d, required 2", bus.kill_count); end
    if (bus.occupancy !== 3'd2) begin n_fail++; $display("FAIL flush_occupancy: got %0d, required 2", bus.occupancy); end
    step();
    @(negedge clk);
    n_checks += 2;
    if (bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_done_pulse: got %b, required 0", bus.flush_done); end
    if (bus.kill_count !== 3'd2) begin n_fail++; $display("FAIL flush_kill_held: got %0d, required 2", bus.kill_count); end
    step();
    bus.out_ready = 1'b1;
    drain(20);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_flush_moving();
    logic [3:0] ids [4] = '{4'd6, 4'd7, 4'd6, 4'd7};
    idle();
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      drive(32'h600 + i, ids[i]);
      if (i != 2) push_exp(32'h600 + i + SUM, ids[i]);
      step();
    end
    idle();
    // Head id 6 is leaving this cycle and must survive; the id 6 in transit must die.
    bus.in_flush = 1'b1; bus.in_flush_id = 4'd6;
    @(negedge clk);
    step();
    bus.in_flush = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (bus.kill_count !== 3'd1) begin n_fail++; $display("FAIL moving_kill: got %0d, required 1", bus.kill_count); end
    if (bus.flush_done !== 1'b1) begin n_fail++; $display("FAIL moving_done: got %b, required 1", bus.flush_done); end
    drain(20);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL moving_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_simultaneous();
    idle();
    bus.out_ready = 1'b0;
    step();
    drive(32'h300, 4'd5);
    push_exp(32'h300 + SUM, 4'd5);
    step();
    idle();
    repeat (4) step();
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_setup: got out_valid %b, required 1", bus.out_valid); end
    step();
    bus.out_ready = 1'b1;
    bus.in_flush = 1'b1; bus.in_flush_id = 4'd5;
    drive(32'h301, 4'd5);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_in_ready: got %b, required 1", bus.in_ready); end
    step();
    idle();
    @(negedge clk);
    n_checks += 3;
    if (bus.kill_count !== 3'd1) begin n_fail++; $display("FAIL simul_kill: got %0d, required 1", bus.kill_count); end
    if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL simul_occupancy: got %0d, required 0", bus.occupancy); end
    if (bus.flush_done !== 1'b1) begin n_fail++; $display("FAIL simul_done: got %b, required 1", bus.flush_done); end
    repeat (8) step();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_midflight();
    idle();
    bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(32'h500 + i, 4'(8 + i));
      step();
    end
    idle();
    repeat (3) step();
    @(negedge clk);
    n_checks += 2;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b, required 1", bus.out_valid); end
    if (bus.occupancy !== 3'd3) begin n_fail++; $display("FAIL mid_pre_occupancy: got %0d, required 3", bus.occupancy); end
    #2 reset = 1'b1;
    #1;
    n_checks += 3;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b, required 0", bus.out_valid); end
    if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL mid_occupancy: got %0d, required 0", bus.occupancy); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b, required 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) step();
    n_checks++;
    if (bus.occupancy !== 3'd0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL mid_after: got occupancy %0d pending %0d, required 0 0", bus.occupancy, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int start;
    int seen = -1;
    step();
    start = cycle;
    bus8.in_valid = 1'b1; bus8.in_address = 8'hFA; bus8.in_id = 4'd3;
    $display("in8  cycle %0d addr=fa id=3", cycle);
    step();
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.out_valid === 1'b1 && seen < 0) begin
        seen = cycle;
        $display("out8 cycle %0d addr=%h id=%0d", cycle, bus8.out_address, bus8.out_id);
        n_checks++;
        if (bus8.out_address !== 8'h18 || bus8.out_id !== 4'd3) begin
          n_fail++; $display("FAIL wrap_data: got addr=%h id=%0d, required addr=18 id=3", bus8.out_address, bus8.out_id);
        end
      end
      @(posedge clk);
    end
    n_checks++;
    if (seen != start + 4) begin n_fail++; $display("FAIL wrap_latency: got cycle %0d, required %0d", seen, start + 4); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_moving();
    test_simultaneous();
    test_reset_midflight();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
